// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline's I/D line ports, the arbiter and the
// downstream L2 line port. The arbiter takes the slave view; the driver of upstream requests and L2 takes master.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WIDTH = 128,
  parameter int SEL_WIDTH  = 16
) ();
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [SEL_WIDTH-1:0]  d_sel;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [SEL_WIDTH-1:0]  l2_sel;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata, d_sel,
    output d_rdata, d_resp,
    output l2_read, l2_write, l2_address, l2_wdata, l2_sel,
    input  l2_rdata, l2_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata, d_sel,
    input  d_rdata, d_resp,
    input  l2_read, l2_write, l2_address, l2_wdata, l2_sel,
    output l2_rdata, l2_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising ifetch (I) and data (D) line requests onto
// one downstream line-memory port; one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WIDTH = 128,
  parameter int SEL_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  state_t                r_state;
  state_t                w_state_nxt;
  grant_t                r_last_grant;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;

  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_serve;
  logic w_complete;

  assign w_d_req    = bus.d_read | bus.d_write;
  assign w_serve    = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);
  assign w_complete = w_serve & bus.l2_resp;

  // Grants are only issued from IDLE; on contention the side not served last wins.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == ST_IDLE) begin
      if (bus.i_read && w_d_req) begin
        w_grant_d = (r_last_grant == GNT_I);
        w_grant_i = (r_last_grant == GNT_D);
      end else begin
        w_grant_i = bus.i_read;
        w_grant_d = w_d_req;
      end
    end else begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_SERVE_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (bus.l2_resp) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture; reads carry all-ones byte enables and zero write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_write <= 1'b0;
      r_address  <= {ADDR_WIDTH{1'b0}};
      r_wdata    <= {LINE_WIDTH{1'b0}};
      r_sel      <= {SEL_WIDTH{1'b0}};
    end else if (w_grant_d) begin
      r_op_write <= bus.d_write;
      r_address  <= bus.d_address;
      r_wdata    <= bus.d_write ? bus.d_wdata : {LINE_WIDTH{1'b0}};
      r_sel      <= bus.d_write ? bus.d_sel : {SEL_WIDTH{1'b1}};
    end else if (w_grant_i) begin
      r_op_write <= 1'b0;
      r_address  <= bus.i_address;
      r_wdata    <= {LINE_WIDTH{1'b0}};
      r_sel      <= {SEL_WIDTH{1'b1}};
    end else begin
      r_op_write <= r_op_write;
    end
  end

  // Completion: capture the returned line for the served side and remember who was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_rdata    <= {LINE_WIDTH{1'b0}};
      r_d_rdata    <= {LINE_WIDTH{1'b0}};
      r_last_grant <= GNT_I;
    end else if (w_complete) begin
      if (r_state == ST_SERVE_I) begin
        r_i_rdata    <= bus.l2_rdata;
        r_last_grant <= GNT_I;
      end else begin
        r_d_rdata    <= bus.l2_rdata;
        r_last_grant <= GNT_D;
      end
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign bus.l2_read    = w_serve & ~r_op_write;
  assign bus.l2_write   = w_serve & r_op_write;
  assign bus.l2_address = w_serve ? r_address : {ADDR_WIDTH{1'b0}};
  assign bus.l2_wdata   = w_serve ? r_wdata : {LINE_WIDTH{1'b0}};
  assign bus.l2_sel     = w_serve ? r_sel : {SEL_WIDTH{1'b0}};

  assign bus.i_resp  = (r_state == ST_DONE) && (r_last_grant == GNT_I);
  assign bus.d_resp  = (r_state == ST_DONE) && (r_last_grant == GNT_D);
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         ir;
    logic [11:0]  ia;
    logic         dr;
    logic         dw;
    logic [11:0]  da;
    logic [127:0] dwd;
    logic [15:0]  ds;
    int           lat;
    logic [127:0] rd;
    logic         exp_d;
    logic [11:0]  exp_addr;
    logic         exp_wr;
    logic [15:0]  exp_sel;
  } vec_t;

  vec_t vecs [7];

  logic [127:0] mem [16];
  logic [11:0]  ri_a, rd_a;
  logic         rd_r, rd_w;
  logic [127:0] rd_wd, given;
  logic [15:0]  rd_s;
  logic         act_i, act_d, busy, sent, due, sdx, m_last_d, prev_i, prev_d, strobe, exp_side;
  int           lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_read    = 1'b0;
    bus.i_address = 12'h000;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = 12'h000;
    bus.d_wdata   = 128'h0;
    bus.d_sel     = 16'h0000;
    bus.l2_rdata  = 128'h0;
    bus.l2_resp   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " l2_read"},    128'(bus.l2_read),    128'(1'b0));
    chk({nm, " l2_write"},   128'(bus.l2_write),   128'(1'b0));
    chk({nm, " l2_address"}, 128'(bus.l2_address), 128'(12'h000));
    chk({nm, " l2_wdata"},   bus.l2_wdata,         128'h0);
    chk({nm, " l2_sel"},     128'(bus.l2_sel),     128'(16'h0000));
    chk({nm, " i_resp"},     128'(bus.i_resp),     128'(1'b0));
    chk({nm, " d_resp"},     128'(bus.d_resp),     128'(1'b0));
    chk({nm, " i_rdata"},    bus.i_rdata,          128'h0);
    chk({nm, " d_rdata"},    bus.d_rdata,          128'h0);
  endtask

  // Act as L2 for one transaction: wait for the strobe, check it, hold for lat cycles, respond, check the pulse.
  task automatic serve(input string nm, input logic exp_d, input logic [11:0] ea, input logic ewr,
                       input logic [15:0] es, input logic [127:0] ew, input int lt,
                       input logic [127:0] rdat, input logic mutate);
    int n;
    n = 0;
    while (!(bus.l2_read || bus.l2_write) && n < 8) begin
      step();
      n++;
    end
    if (!(bus.l2_read || bus.l2_write)) begin
      chk({nm, " strobe seen"}, 128'(1'b0), 128'(1'b1));
      return;
    end
    chk({nm, " l2_read"},    128'(bus.l2_read),    128'(!ewr));
    chk({nm, " l2_write"},   128'(bus.l2_write),   128'(ewr));
    chk({nm, " l2_address"}, 128'(bus.l2_address), 128'(ea));
    chk({nm, " l2_sel"},     128'(bus.l2_sel),     128'(es));
    chk({nm, " l2_wdata"},   bus.l2_wdata,         ew);
    if (mutate) begin
      bus.d_address = 12'h555;
      bus.d_read    = 1'b0;
      bus.d_write   = 1'b0;
    end
    for (int k = 0; k < lt; k++) begin
      step();
      chk({nm, " held strobe"},  128'(bus.l2_read | bus.l2_write), 128'(1'b1));
      chk({nm, " held address"}, 128'(bus.l2_address), 128'(ea));
    end
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = rdat;
    step();
    bus.l2_resp  = 1'b0;
    chk({nm, " i_resp"}, 128'(bus.i_resp), 128'(!exp_d));
    chk({nm, " d_resp"}, 128'(bus.d_resp), 128'(exp_d));
    chk({nm, " rdata"},  exp_d ? bus.d_rdata : bus.i_rdata, rdat);
    chk({nm, " l2 quiet in done"}, 128'(bus.l2_read | bus.l2_write), 128'(1'b0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;

    vecs[0] = '{1'b1, 12'h040, 1'b1, 1'b0, 12'h800, 128'h0, 16'h0000, 1, {16{8'h11}},
                1'b1, 12'h800, 1'b0, 16'hFFFF};
    vecs[1] = '{1'b1, 12'h040, 1'b0, 1'b0, 12'h000, 128'h0, 16'h0000, 3, {16{8'hA5}},
                1'b0, 12'h040, 1'b0, 16'hFFFF};
    vecs[2] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h123, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF,
                16'h0003, 2, {16{8'h5C}}, 1'b1, 12'h123, 1'b1, 16'h0003};
    vecs[3] = '{1'b1, 12'h100, 1'b1, 1'b0, 12'h200, 128'h0, 16'h0000, 0, {16{8'h3C}},
                1'b0, 12'h100, 1'b0, 16'hFFFF};
    vecs[4] = '{1'b1, 12'h101, 1'b1, 1'b1, 12'h2F0, {4{32'hCAFE_F00D}}, 16'hF0F0, 1, {16{8'h77}},
                1'b1, 12'h2F0, 1'b1, 16'hF0F0};
    vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7FF, 128'h0, 16'h0000, 2, {8{16'hBEAD}},
                1'b1, 12'h7FF, 1'b0, 16'hFFFF};
    vecs[6] = '{1'b1, 12'hFFF, 1'b1, 1'b0, 12'h000, 128'h0, 16'h0000, 0, {16{8'hE1}},
                1'b0, 12'hFFF, 1'b0, 16'hFFFF};

    // Table: round-robin starts with D after reset and alternates on contention.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.i_read    = vecs[k].ir;
      bus.i_address = vecs[k].ia;
      bus.d_read    = vecs[k].dr;
      bus.d_write   = vecs[k].dw;
      bus.d_address = vecs[k].da;
      bus.d_wdata   = vecs[k].dwd;
      bus.d_sel     = vecs[k].ds;
      serve($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].exp_addr, vecs[k].exp_wr,
            vecs[k].exp_sel, vecs[k].exp_wr ? vecs[k].dwd : 128'h0, vecs[k].lat, vecs[k].rd, 1'b0);
      clear_inputs();
      step();
      chk($sformatf("vec%0d single pulse", k), 128'(bus.i_resp | bus.d_resp), 128'(1'b0));
    end

    // Reset clears everything, including previously captured read lines.
    do_reset();
    chk_all_zero("reset");

    // Contention held from reset: D, I, D, I.
    clear_inputs();
    rst = 1'b1;
    bus.i_read = 1'b1; bus.i_address = 12'h001;
    bus.d_read = 1'b1; bus.d_address = 12'h800;
    step();
    step();
    rst = 1'b0;
    serve("rr1 D", 1'b1, 12'h800, 1'b0, 16'hFFFF, 128'h0, 1, {16{8'hD1}}, 1'b0);
    serve("rr2 I", 1'b0, 12'h001, 1'b0, 16'hFFFF, 128'h0, 0, {16{8'h11}}, 1'b0);
    serve("rr3 D", 1'b1, 12'h800, 1'b0, 16'hFFFF, 128'h0, 2, {16{8'hD2}}, 1'b0);
    serve("rr4 I", 1'b0, 12'h001, 1'b0, 16'hFFFF, 128'h0, 0, {16{8'h22}}, 1'b0);
    clear_inputs();

    // Input changes and withdrawal during SERVE_D are ignored; d_resp still pulses once.
    do_reset();
    bus.d_read = 1'b1; bus.d_address = 12'h300;
    serve("stab", 1'b1, 12'h300, 1'b0, 16'hFFFF, 128'h0, 3, {16{8'h9E}}, 1'b1);
    step();
    chk("stab no second d_resp", 128'(bus.d_resp), 128'(1'b0));
    step();
    chk("stab no regrant", 128'(bus.l2_read | bus.l2_write), 128'(1'b0));

    // Reset mid-SERVE_I, then a late and a spurious l2_resp while idle.
    do_reset();
    bus.i_read = 1'b1; bus.i_address = 12'h0AA;
    step();
    step();
    chk("midrst strobe up", 128'(bus.l2_read), 128'(1'b1));
    rst = 1'b1;
    bus.i_read = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst strobe dropped", 128'(bus.l2_read | bus.l2_write), 128'(1'b0));
    bus.l2_resp = 1'b1; bus.l2_rdata = {16{8'h66}};
    step();
    bus.l2_resp = 1'b0;
    chk("midrst late resp i_resp", 128'(bus.i_resp), 128'(1'b0));
    step();
    chk("midrst late resp i_resp2", 128'(bus.i_resp), 128'(1'b0));
    chk("midrst i_rdata kept", bus.i_rdata, 128'h0);
    bus.i_read = 1'b1; bus.i_address = 12'h0AB;
    bus.d_read = 1'b1; bus.d_address = 12'h0CD;
    serve("midrst regrant", 1'b1, 12'h0CD, 1'b0, 16'hFFFF, 128'h0, 1, {16{8'h4D}}, 1'b0);
    clear_inputs();
    step();
    step();
    bus.l2_resp = 1'b1; bus.l2_rdata = {16{8'hEE}};
    step();
    bus.l2_resp = 1'b0;
    step();
    chk("spurious resp", 128'(bus.i_resp | bus.d_resp), 128'(1'b0));
    chk("spurious d_rdata kept", bus.d_rdata, {16{8'h4D}});

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = {4{32'h5A00_0000 + 32'(i)}};
    act_i = 1'b0; act_d = 1'b0; busy = 1'b0; sent = 1'b0; due = 1'b0; sdx = 1'b0;
    m_last_d = 1'b0; prev_i = 1'b0; prev_d = 1'b0; lat = 0; given = 128'h0;
    ri_a = 12'h000; rd_a = 12'h000; rd_r = 1'b0; rd_w = 1'b0; rd_wd = 128'h0; rd_s = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (due) begin
        chk("rnd i_resp", 128'(bus.i_resp), 128'(!sdx));
        chk("rnd d_resp", 128'(bus.d_resp), 128'(sdx));
        chk("rnd rdata", sdx ? bus.d_rdata : bus.i_rdata, given);
        if (sdx) begin
          if (rd_w) begin
            for (int b = 0; b < 16; b++)
              if (rd_s[b]) mem[rd_a[3:0]][8*b +: 8] = rd_wd[8*b +: 8];
          end
          act_d = 1'b0;
        end else begin
          act_i = 1'b0;
        end
        m_last_d = sdx;
        busy = 1'b0;
        due  = 1'b0;
      end else begin
        chk("rnd no resp", 128'(bus.i_resp | bus.d_resp), 128'(1'b0));
      end
      strobe = bus.l2_read | bus.l2_write;
      if (!busy && strobe) begin
        chk("rnd strobe needs request", 128'(prev_i | prev_d), 128'(1'b1));
        exp_side = prev_d && (!prev_i || !m_last_d);
        chk("rnd grant address", 128'(bus.l2_address), 128'(exp_side ? rd_a : ri_a));
        chk("rnd grant write", 128'(bus.l2_write), 128'(exp_side && rd_w));
        chk("rnd grant sel", 128'(bus.l2_sel), 128'((exp_side && rd_w) ? rd_s : 16'hFFFF));
        chk("rnd grant wdata", bus.l2_wdata, (exp_side && rd_w) ? rd_wd : 128'h0);
        busy = 1'b1; sent = 1'b0; sdx = exp_side;
        lat = $urandom_range(0, 3);
      end else if (busy && !sent) begin
        chk("rnd strobe held", 128'(strobe), 128'(1'b1));
        chk("rnd address held", 128'(bus.l2_address), 128'(sdx ? rd_a : ri_a));
      end else begin
        chk("rnd no strobe", 128'(strobe), 128'(1'b0));
      end
      bus.l2_resp = 1'b0;
      if (busy && !sent) begin
        if (lat == 0) begin
          given = (sdx && rd_w) ? {$urandom, $urandom, $urandom, $urandom}
                                : mem[sdx ? rd_a[3:0] : ri_a[3:0]];
          bus.l2_resp = 1'b1; bus.l2_rdata = given;
          sent = 1'b1; due = 1'b1;
        end else begin
          lat--;
        end
      end else if (!busy && !due && ($urandom_range(0, 15) == 0)) begin
        bus.l2_resp = 1'b1; bus.l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!act_i && ($urandom_range(0, 2) == 0)) begin
        act_i = 1'b1;
        ri_a  = {8'h00, 4'($urandom_range(0, 15))};
      end
      if (!act_d && ($urandom_range(0, 2) == 0)) begin
        act_d = 1'b1;
        rd_a  = {8'h00, 4'($urandom_range(0, 15))};
        case ($urandom_range(0, 2))
          0:       begin rd_r = 1'b1; rd_w = 1'b0; end
          1:       begin rd_r = 1'b0; rd_w = 1'b1; end
          default: begin rd_r = 1'b1; rd_w = 1'b1; end
        endcase
        rd_wd = {$urandom, $urandom, $urandom, $urandom};
        rd_s  = 16'($urandom);
      end
      bus.i_read    = act_i;
      bus.i_address = act_i ? ri_a : 12'($urandom);
      bus.d_read    = act_d && rd_r;
      bus.d_write   = act_d && rd_w;
      bus.d_address = act_d ? rd_a : 12'($urandom);
      bus.d_wdata   = rd_wd;
      bus.d_sel     = rd_s;
      prev_i = bus.i_read;
      prev_d = bus.d_read | bus.d_write;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
